shift_buffer_ctrl: RTL and testbench
====================================

# shift_buffer_ctrl

Sequencer for the 32×128-bit skewing shift buffer that feeds the systolic array. Runs one tile of up to 16 input vectors per pass: clears the buffer, writes N vectors at consecutive addresses (the buffer applies the per-lane diagonal skew), then drains the N+15 skewed rows to the array under the array's flow control. Sits between the operand loader (valid/ready stream) and the array's row input.

## Interface
- DATA_W, 128, vector width (16 byte lanes)
- ADDR_W, 5, buffer address width
- LANES, 16, byte lanes per vector and maximum vectors per tile
- CLK  in  1  clock, all logic on posedge
- RESET  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a tile; honoured only in IDLE
- vec_cnt  in  5  vectors in tile N, sampled on accepted start; 0 or >16 treated as 16
- in_valid  in  1  loader beat valid
- in_ready  out  1  controller accepts a beat
- in_data  in  DATA_W  loader vector
- buf_RESET  out  1  buffer clear
- buf_RETN  out  1  buffer retention enable; constant 1
- buf_WEN  out  1  buffer write enable, active low
- buf_CEN  out  1  buffer read enable, active low
- buf_A  out  ADDR_W  buffer address
- buf_D  out  DATA_W  buffer write data
- buf_Q  in  DATA_W  buffer read data (registered, 1-cycle latency)
- array_ready  in  1  array can take a row this cycle
- out_valid  out  1  out_data holds a skewed row
- out_data  out  DATA_W  row to array
- out_last  out  1  marks final row of tile
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final row delivered

## Operation
- States: IDLE, CLEAR, FILL, DRAIN, DONE. Registers: state, n (5b), wr_ptr (5b), rd_ptr (5b), rd_issued (1b), last_issued (1b).
- IDLE: start -> latch n, wr_ptr=rd_ptr=0 -> CLEAR.
- CLEAR (exactly 1 cycle): buf_RESET=1 -> FILL.
- FILL: in_ready=1. On in_valid&in_ready: buf_WEN=0, buf_A=wr_ptr, buf_D=in_data, wr_ptr++. Accepting beat with wr_ptr==n-1 -> DRAIN. in_valid low: no write, stay.
- DRAIN: if array_ready: buf_CEN=0, buf_A=rd_ptr, rd_ptr++. Issuing rd_ptr==n+14 -> DONE. array_ready low: buf_CEN=1, no advance.
- DONE (1 cycle): done=1 -> IDLE.
- Output path: rd_issued <= (read issued this cycle); out_valid = rd_issued; out_data = rd_issued ? buf_Q : 0; out_last = rd_issued & last_issued (last_issued registers "issued row was n+14").
- Defaults whenever not driven above: buf_RESET=RESET, buf_WEN=1, buf_CEN=1, buf_A=0, buf_D=0, in_ready=0. Buffer port outputs and in_ready are combinational from state/counters/inputs; never assert WEN=0 and CEN=0 in the same cycle.
- Address range: max write 15, max read 30; no wrap, no address above 30 issued.
- Row content (guaranteed by buffer): row r lane i = byte i of vector r-i if 0 <= r-i < n, else 0.

## Timing
- Reset (RESET=1 at an edge, any state): state=IDLE, counters 0, rd_issued=0; outputs: in_ready=0, buf_RESET=1 while RESET high, buf_WEN=1, buf_CEN=1, buf_A=0, buf_D=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. Reset mid-FILL/DRAIN abandons the tile; no partial done.
- start->first write possible: 2 cycles (IDLE edge, CLEAR cycle). start outside IDLE ignored, never queued.
- Read latency: row issued in cycle t appears on out_valid/out_data in t+1, regardless of array_ready at t+1.
- Final row: out_valid&out_last in the DONE cycle, concurrent with done.
- Minimum tile duration with no stalls: 1 (CLEAR) + n (FILL) + n+15 (DRAIN) + 1 (DONE) cycles after start edge.
- busy high from cycle after accepted start through DONE inclusive.

## Test plan
- N=1, in_data lane i = i+1, array_ready=1 -> 16 rows; row r has only lane r = r+1; out_last on row 15; done same cycle; total 18 cycles after start.
- N=16, vector k all lanes = k+1 -> 31 rows; row r lane i = r-i+1 when 0<=r-i<16 else 0; max buf_A = 30.
- N=4 with array_ready toggling 1,0,0,1 and in_valid gaps -> row sequence unchanged, no duplicate or skipped rows, out_valid only one cycle after each issued read.
- RESET asserted after 3 FILL beats -> all outputs at reset values next cycle; new start with N=2 produces only 17 rows of fresh data, no stale bytes.
- start pulsed during DRAIN -> ignored, single done; vec_cnt=0 -> tile runs as N=16 (31 rows).

Source files
------------

// File: rtl/shift_buffer_ctrl.sv
// Tile sequencer for the 32x128 skewing shift buffer: clear, fill N vectors,
// then drain N+15 skewed rows to the systolic array under array_ready.
module shift_buffer_ctrl #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 5,
    parameter int LANES  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] vec_cnt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              buf_RESET,
    output logic              buf_RETN,
    output logic              buf_WEN,
    output logic              buf_CEN,
    output logic [ADDR_W-1:0] buf_A,
    output logic [DATA_W-1:0] buf_D,
    input  logic [DATA_W-1:0] buf_Q,
    input  logic              array_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, CLEAR, FILL, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] MAX_N = ADDR_W'(LANES);
    localparam logic [ADDR_W-1:0] SKEW  = ADDR_W'(LANES - 2);

    state_t            r_state;
    logic [ADDR_W-1:0] r_n;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_rd_issued;
    logic              r_last_issued;

    logic              w_wr;
    logic              w_rd;
    logic [ADDR_W-1:0] w_n_clamped;
    logic [ADDR_W-1:0] w_last_wr;
    logic [ADDR_W-1:0] w_last_rd;

    assign w_n_clamped = (vec_cnt == '0 || vec_cnt > MAX_N) ? MAX_N : vec_cnt;
    assign w_last_wr   = r_n - ADDR_W'(1);
    // Final skewed row sits LANES-1 rows past the last vector: index n+14.
    assign w_last_rd   = r_n + SKEW;

    // Buffer port drive is held at idle values while RESET is high so an
    // abandoned tile cannot write or read on the reset cycle.
    always_comb begin
        w_wr      = 1'b0;
        w_rd      = 1'b0;
        in_ready  = 1'b0;
        buf_RESET = RESET;
        buf_WEN   = 1'b1;
        buf_CEN   = 1'b1;
        buf_A     = '0;
        buf_D     = '0;
        if (!RESET) begin
            case (r_state)
                CLEAR: buf_RESET = 1'b1;
                FILL: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        w_wr    = 1'b1;
                        buf_WEN = 1'b0;
                        buf_A   = r_wr_ptr;
                        buf_D   = in_data;
                    end
                end
                DRAIN: begin
                    if (array_ready) begin
                        w_rd    = 1'b1;
                        buf_CEN = 1'b0;
                        buf_A   = r_rd_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_n           <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_rd_issued   <= 1'b0;
            r_last_issued <= 1'b0;
        end else begin
            r_rd_issued   <= w_rd;
            r_last_issued <= w_rd && (r_rd_ptr == w_last_rd);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n      <= w_n_clamped;
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        r_state  <= CLEAR;
                    end
                end
                CLEAR: r_state <= FILL;
                FILL: begin
                    if (w_wr) begin
                        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                        if (r_wr_ptr == w_last_wr) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_rd) begin
                        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                        if (r_rd_ptr == w_last_rd) r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign buf_RETN  = 1'b1;
    assign out_valid = r_rd_issued;
    assign out_data  = r_rd_issued ? buf_Q : '0;
    assign out_last  = r_rd_issued & r_last_issued;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_shift_buffer_ctrl.sv
// Bench for shift_buffer_ctrl: behavioural skew buffer, row-level reference
// model with per-cycle compare, plus directed tiles with literal row values.
module tb_shift_buffer_ctrl;
    localparam int DW = 128;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          start = 1'b0;
    logic [4:0]    vec_cnt = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          buf_RESET, buf_RETN, buf_WEN, buf_CEN;
    logic [4:0]    buf_A;
    logic [DW-1:0] buf_D;
    logic [DW-1:0] buf_Q;
    logic          array_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last, busy, done;

    shift_buffer_ctrl dut (
        .CLK(CLK), .RESET(RESET), .start(start), .vec_cnt(vec_cnt),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .buf_RESET(buf_RESET), .buf_RETN(buf_RETN), .buf_WEN(buf_WEN),
        .buf_CEN(buf_CEN), .buf_A(buf_A), .buf_D(buf_D), .buf_Q(buf_Q),
        .array_ready(array_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Skewing buffer: vector written at address a puts lane i into row a+i.
    logic [DW-1:0] mem [0:31];
    always @(posedge CLK) begin
        if (buf_RESET) begin
            for (int r = 0; r < 32; r++) mem[r] <= '0;
        end else if (!buf_WEN) begin
            for (int i = 0; i < 16; i++) mem[int'(buf_A) + i][8*i +: 8] <= buf_D[8*i +: 8];
        end
        if (!buf_CEN) buf_Q <= mem[buf_A];
    end

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    logic [DW-1:0] vec [0:15];

    // Reference model state (written only by the compare process)
    bit            m_busy = 0, start_pend = 0, rd_prev = 0, rdy_prev = 0;
    int            m_n = 16, pend_n = 16, m_next = 0, m_done_cnt = 0;
    int            max_a = 0, start_cyc = 0, done_cyc = 0;
    logic [DW-1:0] got [0:31];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int f_n(input logic [4:0] v);
        return (v == 0 || v > 16) ? 16 : int'(v);
    endfunction

    // Row r, lane i carries byte i of vector r-i when that vector exists.
    function automatic logic [DW-1:0] exp_row(input int r);
        logic [DW-1:0] e = '0;
        for (int i = 0; i < 16; i++) begin
            int k = r - i;
            if (k >= 0 && k < m_n) e[8*i +: 8] = vec[k][8*i +: 8];
        end
        return e;
    endfunction

    always @(negedge CLK) begin
        if (RESET) begin
            m_busy = 0; start_pend = 0; rd_prev = 0; rdy_prev = 0;
        end else begin
            if (start_pend) begin
                m_busy = 1; m_n = pend_n; m_next = 0; max_a = 0; start_cyc = cyc;
            end
            chk("retn", buf_RETN, 1);
            chk("wen_cen_excl", !buf_WEN && !buf_CEN, 0);
            chk("busy", busy, m_busy);
            if (!buf_WEN) begin
                chk("wr_addr_max", buf_A <= 15, 1);
                chk("wr_data", buf_D, in_data);
            end
            if (!buf_CEN) begin
                chk("rd_addr_max", buf_A <= 30, 1);
                if (int'(buf_A) > max_a) max_a = int'(buf_A);
            end
            chk("valid_vs_read", out_valid, rd_prev);
            if (out_valid) begin
                chk("valid_after_ready", rdy_prev, 1);
                chk("row_data", out_data, exp_row(m_next));
                chk("row_last", out_last, m_next == m_n + 14);
                if (m_next < 32) got[m_next] = out_data;
                m_next++;
            end else begin
                chk("idle_data", out_data, 0);
                chk("idle_last", out_last, 0);
            end
            if (done) begin
                chk("done_rows", m_next, m_n + 15);
                chk("done_with_last", out_last, 1);
                m_done_cnt++;
                done_cyc = cyc;
            end
            start_pend = start && !m_busy;
            pend_n = f_n(vec_cnt);
            if (done) m_busy = 0;
            rd_prev = !buf_CEN;
            rdy_prev = array_ready;
        end
    end

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1; start = 0; in_valid = 0; array_ready = 0;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_buf_reset", buf_RESET, 1);
        chk("rst_wen", buf_WEN, 1);
        chk("rst_cen", buf_CEN, 1);
        chk("rst_a", buf_A, 0);
        chk("rst_d", buf_D, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge CLK); #1;
        RESET = 0;
    endtask

    task automatic run_tile(input int ncfg, input int rdy_mode, input int gap_mode,
                            input int abort_beats, input int poke_start);
        int beat = 0, c = 0, d0 = m_done_cnt;
        bit hs, poked = 0;
        @(posedge CLK); #1;
        start = 1; vec_cnt = 5'(ncfg);
        @(posedge CLK); #1;
        start = 0;
        while (m_done_cnt == d0 && c < 400) begin
            in_valid = (gap_mode != 0) ? (c % 3 != 1) : 1'b1;
            in_data = vec[beat < 16 ? beat : 15];
            array_ready = (rdy_mode != 0) ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            if (poke_start != 0 && !poked && m_next >= 3) begin
                start = 1; vec_cnt = 5'd3; poked = 1;
            end
            @(negedge CLK);
            hs = in_valid && in_ready;
            @(posedge CLK); #1;
            start = 0;
            if (hs) beat++;
            c++;
            if (abort_beats > 0 && beat == abort_beats) break;
        end
        in_valid = 0; array_ready = 0;
        if (abort_beats == 0) begin
            repeat (5) @(posedge CLK);
            #1;
            chk("single_done", m_done_cnt, d0 + 1);
        end
    endtask

    initial begin
        do_reset();

        // N=1, lane i = i+1
        for (int k = 0; k < 16; k++) vec[k] = '0;
        for (int i = 0; i < 16; i++) vec[0][8*i +: 8] = 8'(i + 1);
        run_tile(1, 0, 0, 0, 0);
        chk("n1_rows", m_next, 16);
        chk("n1_row0", got[0], 128'h01);
        chk("n1_row5", got[5], 128'h0000_0000_0000_0000_0000_0600_0000_0000);
        chk("n1_row15", got[15], 128'h1000_0000_0000_0000_0000_0000_0000_0000);
        chk("n1_done_latency", done_cyc - start_cyc, 18);
        chk("n1_model_pin", exp_row(3), 128'h0400_0000);

        // N=16, vector k all lanes = k+1
        for (int k = 0; k < 16; k++) vec[k] = {16{8'(k + 1)}};
        run_tile(16, 0, 0, 0, 0);
        chk("n16_rows", m_next, 31);
        chk("n16_row0", got[0], 128'h01);
        chk("n16_row15", got[15], 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10);
        chk("n16_row30", got[30], 128'h1000_0000_0000_0000_0000_0000_0000_0000);
        chk("n16_max_a", max_a, 30);
        chk("n16_done_latency", done_cyc - start_cyc, 48);

        // N=4, array_ready 1,0,0,1 and in_valid gaps
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < 16; i++) vec[k][8*i +: 8] = 8'(16 * k + i);
        run_tile(4, 1, 1, 0, 0);
        chk("n4_rows", m_next, 19);
        chk("n4_row3", got[3], 128'h0312_2130);

        // Reset after 3 FILL beats, then a fresh N=2 tile
        for (int k = 0; k < 16; k++) vec[k] = {16{8'hA5}};
        run_tile(4, 0, 0, 3, 0);
        do_reset();
        for (int k = 0; k < 16; k++)
            for (int i = 0; i < 16; i++) vec[k][8*i +: 8] = 8'(8'h80 | (k << 4) | i);
        run_tile(2, 0, 0, 0, 0);
        chk("n2_rows", m_next, 17);
        chk("n2_row0", got[0], 128'h80);
        chk("n2_row16", got[16], 128'h9F00_0000_0000_0000_0000_0000_0000_0000);

        // vec_cnt=0 runs as 16; start during DRAIN ignored
        for (int k = 0; k < 16; k++) vec[k] = {16{8'(8'h11 * (k % 15 + 1))}};
        run_tile(0, 0, 0, 0, 1);
        chk("n0_rows", m_next, 31);
        chk("n0_busy_after", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
